// File: rtl/dual_clock_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer code conversion.
package dual_clock_fifo_pkg;

    localparam int unsigned MaxPtrWidth = 32;

    // XOR prefix from the MSB down; callers zero-extend narrower gray codes.
    function automatic logic [MaxPtrWidth-1:0] gray_to_bin(input logic [MaxPtrWidth-1:0] gray);
        logic [MaxPtrWidth-1:0] bin;
        bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
        for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a synchronous active-low reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dual_clock_fifo.sv
// Asynchronous dual-clock FIFO with gray-coded pointers, first-word-fall-through read
// data and registered full/empty/almost flags.
module dual_clock_fifo
    import dual_clock_fifo_pkg::*;
#(
    parameter int unsigned DATASIZE   = 32,
    parameter int unsigned ADDRSIZE   = 4,
    parameter int unsigned ALMOST_GAP = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                rclk,
    input  logic                rresetn,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    output logic                wfull,
    output logic                almost_full,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic                almost_empty
);

    localparam int unsigned DEPTH = 2 ** ADDRSIZE;

    typedef logic [ADDRSIZE:0] ptr_t;

    // Full when the write gray pointer equals the read one with its two MSBs inverted.
    localparam ptr_t FULL_MASK = ptr_t'(3 << (ADDRSIZE - 1));
    localparam ptr_t AF_LEVEL  = ptr_t'(DEPTH - ALMOST_GAP);
    localparam ptr_t AE_LEVEL  = ptr_t'(ALMOST_GAP);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic wen;
    logic ren;
    ptr_t wbin, wgray, wbin_next, wgray_next, wq2_rgray, wq2_rbin, wcount;
    ptr_t rbin, rgray, rbin_next, rgray_next, rq2_wgray, rq2_wbin, rcount;

    // Write domain
    always_comb begin
        wen        = winc && !wfull;
        wbin_next  = wbin + ptr_t'(wen);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        wq2_rbin   = ptr_t'(gray_to_bin(MaxPtrWidth'(wq2_rgray)));
        wcount     = wbin_next - wq2_rbin;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wbin        <= '0;
            wgray       <= '0;
            wfull       <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            wfull       <= (wgray_next == (wq2_rgray ^ FULL_MASK));
            almost_full <= (wcount >= AF_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wbin[ADDRSIZE-1:0]] <= wdata;
        end
    end

    // Read domain
    always_comb begin
        ren        = rinc && !rempty;
        rbin_next  = rbin + ptr_t'(ren);
        rgray_next = rbin_next ^ (rbin_next >> 1);
        rq2_wbin   = ptr_t'(gray_to_bin(MaxPtrWidth'(rq2_wgray)));
        rcount     = rq2_wbin - rbin_next;
    end

    always_ff @(posedge rclk) begin
        if (!rresetn) begin
            rbin         <= '0;
            rgray        <= '0;
            rempty       <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            rempty       <= (rgray_next == rq2_wgray);
            almost_empty <= (rcount <= AE_LEVEL);
        end
    end

    assign rdata = mem[rbin[ADDRSIZE-1:0]];

    sync_2ff #(
        .WIDTH (ADDRSIZE + 1)
    ) u_sync_rgray (
        .clk    (clk),
        .resetn (resetn),
        .d      (rgray),
        .q      (wq2_rgray)
    );

    sync_2ff #(
        .WIDTH (ADDRSIZE + 1)
    ) u_sync_wgray (
        .clk    (rclk),
        .resetn (rresetn),
        .d      (wgray),
        .q      (rq2_wgray)
    );

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Scoreboard bench for dual_clock_fifo: directed flag/latency cases plus randomized traffic.
`timescale 1ns/1ps
module tb_dual_clock_fifo;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int GAP   = 1;
    localparam int DEPTH = 4;

    logic          clk     = 1'b0;
    logic          rclk    = 1'b0;
    logic          resetn  = 1'b0;
    logic          rresetn = 1'b0;
    logic          winc    = 1'b0;
    logic          rinc    = 1'b0;
    logic [DW-1:0] wdata   = '0;
    logic [DW-1:0] rdata;
    logic          wfull, almost_full, rempty, almost_empty;

    realtime rhalf = 6.735;
    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_pop  = 0;
    logic [DW-1:0] sb [$];

    always #5 clk = ~clk;
    always #(rhalf) rclk = ~rclk;

    dual_clock_fifo #(
        .DATASIZE   (DW),
        .ADDRSIZE   (AW),
        .ALMOST_GAP (GAP)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rclk         (rclk),
        .rresetn      (rresetn),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .almost_full  (almost_full),
        .rinc         (rinc),
        .rdata        (rdata),
        .rempty       (rempty),
        .almost_empty (almost_empty)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Write-side monitor: an accepted write must fit in the true occupancy.
    always @(negedge clk) begin
        if (resetn && winc && !wfull) begin
            check("occupancy_le_depth", DW'(sb.size() < DEPTH), 1);
            sb.push_back(wdata);
            n_push++;
        end
    end

    // Read-side monitor: every accepted pop must return the oldest unread word.
    always @(negedge rclk) begin
        if (rresetn && rinc && !rempty) begin
            check("read_has_data", DW'(sb.size() != 0), 1);
            if (sb.size() != 0) check("rdata_order", rdata, sb.pop_front());
            n_pop++;
        end
    end

    // Flags once both synchronisers have caught up, derived from the true occupancy.
    task automatic check_flags(input string tag);
        int occ;
        repeat (6) @(posedge clk);
        repeat (6) @(posedge rclk);
        #1;
        occ = sb.size();
        check({tag, "_wfull"}, wfull, occ == DEPTH);
        check({tag, "_almost_full"}, almost_full, occ >= DEPTH - GAP);
        check({tag, "_rempty"}, rempty, occ == 0);
        check({tag, "_almost_empty"}, almost_empty, occ <= GAP);
        check({tag, "_not_full_and_empty"}, wfull && rempty, 0);
    endtask

    task automatic reset_both();
        fork
            begin
                @(posedge clk); #1 resetn = 1'b0;
                repeat (2) @(posedge clk);
                #1 resetn = 1'b1;
            end
            begin
                @(posedge rclk); #1 rresetn = 1'b0;
                repeat (2) @(posedge rclk);
                #1 rresetn = 1'b1;
            end
        join
        sb.delete();
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        @(posedge clk); #1;
        winc  = 1'b1;
        wdata = d;
        @(posedge clk); #1;
        winc  = 1'b0;
    endtask

    task automatic read_words(input int count, input string name);
        int target = n_pop + count;
        int budget = 60;
        @(posedge rclk); #1;
        rinc = 1'b1;
        while (n_pop < target && budget > 0) begin
            @(posedge rclk); #1;
            budget--;
        end
        rinc = 1'b0;
        check(name, n_pop, target);
    endtask

    task automatic wait_not_empty(input string name);
        int edges = 0;
        while (rempty && edges < 3) begin
            @(posedge rclk); #1;
            edges++;
        end
        check(name, rempty, 0);
    endtask

    task automatic random_phase(input int words, input int wr_pct, input int rd_pct,
                                input bit no_b2b);
        int wt = n_push + words;
        int rt = n_pop + words;
        fork
            begin
                int budget = 40000;
                forever begin
                    @(posedge clk); #1;
                    if (n_push >= wt || budget == 0) break;
                    budget--;
                    winc  = ($urandom_range(99) < wr_pct);
                    wdata = $urandom;
                end
                winc = 1'b0;
                check("random_writes_done", n_push, wt);
            end
            begin
                int budget = 40000;
                forever begin
                    @(posedge rclk); #1;
                    if (n_pop >= rt || budget == 0) break;
                    budget--;
                    // Spaced pops keep a fast reader from draining before wfull can release.
                    if (no_b2b && rinc) rinc = 1'b0;
                    else rinc = ($urandom_range(99) < rd_pct);
                end
                rinc = 1'b0;
                check("random_reads_done", n_pop, rt);
            end
        join
    endtask

    initial begin
        #600us;
        $display("FAIL watchdog: time limit hit with %0d pops of %0d pushes", n_pop, n_push);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_both();
        check_flags("reset");

        @(posedge rclk); #1 rinc = 1'b1;
        repeat (3) @(posedge rclk);
        #1 rinc = 1'b0;
        check("idle_rinc_no_pop", n_pop, 0);
        check("idle_rempty", rempty, 1);

        for (int k = 1; k <= DEPTH; k++) begin
            write_word(DW'(k));
            check("fill_almost_full", almost_full, k >= DEPTH - GAP);
            check("fill_wfull", wfull, k == DEPTH);
        end
        write_word(DW'(5));
        check("drop_wfull", wfull, 1);
        check_flags("full");
        read_words(DEPTH, "drain_count");
        check("drain_rempty", rempty, 1);
        check("drain_almost_empty", almost_empty, 1);
        check_flags("drained");

        write_word(32'hDEAD_BEEF);
        wait_not_empty("single_rempty_fall");
        check("single_fwft_rdata", rdata, 32'hDEAD_BEEF);
        check("single_almost_empty", almost_empty, 1);
        rinc = 1'b1;
        @(posedge rclk); #1;
        rinc = 1'b0;
        check("single_rempty_after_pop", rempty, 1);
        check_flags("single");

        random_phase(5000, 90, 60, 1'b0);
        check_flags("fast_write");
        rhalf = 3.85;
        repeat (4) @(posedge rclk);
        random_phase(5000, 75, 100, 1'b1);
        check_flags("fast_read");

        for (int k = 0; k < 3; k++) write_word(32'h1111_0000 + DW'(k));
        check_flags("pre_reset");
        reset_both();
        check_flags("mid_reset");
        write_word(32'hA5A5_5A5A);
        wait_not_empty("post_reset_rempty_fall");
        read_words(1, "post_reset_pop");
        check("post_reset_rempty", rempty, 1);
        check_flags("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
